// File: rtl/sram_bist_engine.sv
// Write-then-read BIST engine for synchronous burst SRAMs: patterned writes with per-byte
// even parity, latency-aligned read-back compare, saturating error count and first-fail capture.
module sram_bist_engine #(
  parameter int BYTES     = 2,
  parameter int ADDR_W    = 16,
  parameter int NUM_WORDS = 256,
  parameter int RD_LAT    = 2,
  parameter int ERR_W     = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  invert,
  input  logic [9*BYTES-1:0]    mask,
  output logic [ADDR_W-1:0]     sram_a,
  output logic                  sram_ceb,
  output logic                  sram_bweb,
  output logic [BYTES-1:0]      sram_bwb,
  output logic                  sram_oeb,
  output logic [9*BYTES-1:0]    sram_dout,
  output logic                  sram_dout_en,
  input  logic [9*BYTES-1:0]    sram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [9*BYTES-1:0]    fail_data
);

  localparam int W = 9 * BYTES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(RD_LAT - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;

  typedef enum logic [2:0] {IDLE, WRITE, TURN, READ, DRAIN, DONE} state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [2:0]          drain_cnt, drain_n;
  logic [1:0]          mode_q, mode_use;
  logic                inv_q, inv_use;
  logic                accept;

  logic                pipe_v [RD_LAT];
  logic [ADDR_W-1:0]   pipe_a [RD_LAT];
  logic [W-1:0]        pipe_d [RD_LAT];

  logic [W-1:0]        diff;
  logic                mismatch;
  logic [ERR_W-1:0]    err_n;

  // Each byte lane carries 8 pattern bits topped by their even-parity bit.
  function automatic logic [W-1:0] pattern(input logic [1:0] m, input logic inv,
                                           input logic [ADDR_W-1:0] a);
    logic [W-1:0] w;
    logic [7:0]   a8;
    logic [7:0]   b;
    w  = '0;
    a8 = 8'(a);
    for (int i = 0; i < BYTES; i++) begin
      case (m)
        2'd0:    b = a8 + 8'(i);
        2'd1:    b = (a8[0] ^ i[0]) ? 8'hAA : 8'h55;
        2'd2:    b = 8'd1 << (a8[2:0] + 3'(i));
        default: b = 8'h00;
      endcase
      if (inv) b = ~b;
      w[9*i +: 9] = {^b, b};
    end
    return w;
  endfunction

  always_comb begin
    state_n = state;
    addr_n  = addr;
    drain_n = drain_cnt;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = WRITE;
          addr_n  = '0;
        end
      end
      WRITE: begin
        if (addr == LAST_ADDR) begin
          state_n = TURN;
          addr_n  = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      TURN: begin
        state_n = READ;
        addr_n  = '0;
      end
      READ: begin
        if (addr == LAST_ADDR) begin
          state_n = DRAIN;
          drain_n = '0;
        end else begin
          addr_n = addr + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) state_n = DONE;
        else                         drain_n = drain_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign mode_use = accept ? mode : mode_q;
  assign inv_use  = accept ? invert : inv_q;

  // X on an unmasked din bit must register as a failure, hence the case inequality.
  assign diff     = (sram_din ^ pipe_d[RD_LAT-1]) & ~mask;
  assign mismatch = pipe_v[RD_LAT-1] && (diff !== '0);
  assign err_n    = (mismatch && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state     <= IDLE;
      addr      <= '0;
      drain_cnt <= '0;
      mode_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      drain_cnt <= drain_n;
      if (accept) begin
        mode_q <= mode;
        inv_q  <= invert;
      end
    end
  end

  // Pin outputs are registered from the next state so they line up with the FSM state.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sram_a       <= '0;
      sram_ceb     <= 1'b1;
      sram_bweb    <= 1'b1;
      sram_bwb     <= '1;
      sram_oeb     <= 1'b1;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      sram_a       <= (state_n == WRITE || state_n == READ) ? addr_n : '0;
      sram_ceb     <= !(state_n == WRITE || state_n == READ);
      sram_bweb    <= !(state_n == WRITE);
      sram_bwb     <= (state_n == WRITE) ? '0 : '1;
      sram_oeb     <= !(state_n == READ || state_n == DRAIN);
      sram_dout    <= (state_n == WRITE) ? pattern(mode_use, inv_use, addr_n) : '0;
      sram_dout_en <= (state_n == WRITE);
      busy         <= (state_n == WRITE || state_n == TURN ||
                       state_n == READ  || state_n == DRAIN);
      done         <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= (state == READ);
      pipe_a[0] <= addr;
      pipe_d[0] <= pattern(mode_q, inv_q, addr);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  // pass is decided on the DRAIN->DONE edge so the final compare is included.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      err_cnt   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      pass      <= 1'b0;
    end else begin
      err_cnt <= err_n;
      if (mismatch && err_cnt == '0) begin
        fail_addr <= pipe_a[RD_LAT-1];
        fail_data <= sram_din;
      end
      if (state == DRAIN && state_n == DONE) pass <= (err_n == '0);
    end
  end

endmodule
